mult_div_unit: RTL and testbench

- Iterative multiply/divide unit with the architectural HI/LO registers.
- Sits directly downstream of the register bank: consumes data_Reg1/data_Reg2 and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Exposes HI/LO to the write-back mux for MFHI/MFLO.
- Generates a stall so the single-cycle datapath holds the PC while a 32-cycle operation is in flight.

---
 rtl/mult_div_unit.sv | 189 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit holding the HI/LO registers.
// MULTU/MULT use one shift-add step per cycle, DIVU/DIV one restoring
// shift-subtract step per cycle; MTHI/MTLO write HI/LO directly from IDLE.
// Optional macro MDU_SIGNED_EN: when defined, MULT/DIV (op_Sel[0]=1) operate
// on two's-complement operands via magnitude conversion and sign fixup;
// when undefined, op_Sel[0] is ignored and both behave as the unsigned op.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_Reg1,
    input  logic [WIDTH-1:0] data_Reg2,
    input  logic             flag_Start,
    input  logic [2:0]       op_Sel,
    input  logic             flag_ReadHiLo,
    output logic [WIDTH-1:0] data_Hi,
    output logic [WIDTH-1:0] data_Lo,
    output logic             flag_Busy,
    output logic             flag_Done,
    output logic             flag_DivZero,
    output logic             flag_Stall
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t next_state;

    logic [CW-1:0]      counter;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   raw_dividend;
    logic               is_div;
    logic               neg_result;
    logic               neg_rem;
    logic               div_zero;

    logic               signed_req;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               start_muldiv;
    logic               start_mthi;
    logic               start_mtlo;
    logic               finish;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

`ifdef MDU_SIGNED_EN
    assign signed_req = op_Sel[0];
`else
    assign signed_req = 1'b0;
`endif

    // Decode requests and convert operands to magnitudes for the signed ops
    always_comb begin
        start_muldiv = flag_Start && (state == IDLE) && !op_Sel[2];
        start_mthi   = flag_Start && (state == IDLE) && (op_Sel == 3'b100);
        start_mtlo   = flag_Start && (state == IDLE) && (op_Sel == 3'b101);
        sign_a       = signed_req & data_Reg1[WIDTH-1];
        sign_b       = signed_req & data_Reg2[WIDTH-1];
        mag_a        = sign_a ? (~data_Reg1 + 1'b1) : data_Reg1;
        mag_b        = sign_b ? (~data_Reg2 + 1'b1) : data_Reg2;
        finish       = (state == RUN) && (counter == '0);
    end

    // One iteration of shift-add (mul) or restoring shift-subtract (div)
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, operand});
        div_sub   = div_shift[WIDTH-1:0] - operand;
        if (is_div) begin
            step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign fixup and divide-by-zero override applied to the final step
    always_comb begin
        product = {step_hi, step_lo};
        if (neg_result) begin
            product = ~product + 1'b1;
        end
        if (!is_div) begin
            res_hi = product[2*WIDTH-1:WIDTH];
            res_lo = product[WIDTH-1:0];
        end else if (div_zero) begin
            res_hi = raw_dividend;
            res_lo = {WIDTH{1'b1}};
        end else begin
            res_hi = neg_rem    ? (~step_hi + 1'b1) : step_hi;
            res_lo = neg_result ? (~step_lo + 1'b1) : step_lo;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE accepts mul/div, RUN lasts until the counter expires
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start_muldiv) next_state = RUN;
            RUN:  if (counter == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: busy follows the RUN state, stall holds the pipeline on a conflict
    always_comb begin
        flag_Busy  = (state == RUN);
        flag_Stall = flag_Busy & (flag_Start | flag_ReadHiLo);
    end

    // Datapath: operand capture, iteration, HI/LO update and completion pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter      <= '0;
            operand      <= '0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            raw_dividend <= '0;
            is_div       <= 1'b0;
            neg_result   <= 1'b0;
            neg_rem      <= 1'b0;
            div_zero     <= 1'b0;
            data_Hi      <= '0;
            data_Lo      <= '0;
            flag_Done    <= 1'b0;
            flag_DivZero <= 1'b0;
        end else begin
            flag_Done    <= finish;
            flag_DivZero <= finish & div_zero;
            if (start_muldiv) begin
                counter      <= CW'(ITER - 1);
                operand      <= mag_b;
                acc_hi       <= '0;
                acc_lo       <= mag_a;
                raw_dividend <= data_Reg1;
                is_div       <= op_Sel[1];
                neg_result   <= sign_a ^ sign_b;
                neg_rem      <= sign_a;
                div_zero     <= op_Sel[1] && (data_Reg2 == '0);
            end else if (state == RUN) begin
                counter <= counter - 1'b1;
                acc_hi  <= step_hi;
                acc_lo  <= step_lo;
                if (finish) begin
                    data_Hi <= res_hi;
                    data_Lo <= res_lo;
                end
            end
            if (start_mthi) begin
                data_Hi <= data_Reg1;
            end
            if (start_mtlo) begin
                data_Lo <= data_Reg1;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed bench for mult_div_unit.
// The reference model computes HI/LO with plain 64-bit arithmetic and
// follows MDU_SIGNED_EN the same way the design build does.
module tb_mult_div_unit;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_Reg1;
    logic [31:0] data_Reg2;
    logic        flag_Start;
    logic [2:0]  op_Sel;
    logic        flag_ReadHiLo;
    logic [31:0] data_Hi;
    logic [31:0] data_Lo;
    logic        flag_Busy;
    logic        flag_Done;
    logic        flag_DivZero;
    logic        flag_Stall;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi = 32'h0;
    logic [31:0] model_lo = 32'h0;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .data_Reg1     (data_Reg1),
        .data_Reg2     (data_Reg2),
        .flag_Start    (flag_Start),
        .op_Sel        (op_Sel),
        .flag_ReadHiLo (flag_ReadHiLo),
        .data_Hi       (data_Hi),
        .data_Lo       (data_Lo),
        .flag_Busy     (flag_Busy),
        .flag_Done     (flag_Done),
        .flag_DivZero  (flag_DivZero),
        .flag_Stall    (flag_Stall)
    );

    // Free-running clock, 10 time units per period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard time limit so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: architectural result of a mul/div operation
    task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        bit          sgn;
        logic [63:0] prod;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
`ifdef MDU_SIGNED_EN
        sgn = op[0];
`else
        sgn = 1'b0;
`endif
        dz = 1'b0;
        if (!op[1]) begin
            if (sgn) begin
                sa   = longint'($signed(a));
                sb   = longint'($signed(b));
                prod = 64'(sa * sb);
            end else begin
                prod = {32'h0, a} * {32'h0, b};
            end
            hi = prod[63:32];
            lo = prod[31:0];
        end else if (b == 32'h0) begin
            dz = 1'b1;
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    // Wait (bounded) for the unit to leave RUN, optionally checking stall/hold each cycle
    task automatic waitIdle(input bit read_during, output int cycles, output bit stall_ok, output bit hold_ok);
        cycles   = 0;
        stall_ok = 1'b1;
        hold_ok  = 1'b1;
        while (flag_Busy && cycles < 100) begin
            if (read_during && flag_Stall !== 1'b1) stall_ok = 1'b0;
            if (data_Hi !== model_hi || data_Lo !== model_lo) hold_ok = 1'b0;
            @(posedge clock);
            #1;
            cycles++;
        end
    endtask

    // Issue one mul/div operation, run it to completion and check the result
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit read_during);
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        int          cycles;
        bit          stall_ok;
        bit          hold_ok;
        modelOp(op, a, b, exp_hi, exp_lo, exp_dz);
        @(negedge clock);
        flag_Start    = 1'b1;
        op_Sel        = op;
        data_Reg1     = a;
        data_Reg2     = b;
        flag_ReadHiLo = 1'b0;
        @(posedge clock);
        #1;
        flag_Start    = 1'b0;
        flag_ReadHiLo = read_during;
        #1;
        waitIdle(read_during, cycles, stall_ok, hold_ok);
        flag_ReadHiLo = 1'b0;
        checkOutput("busy_cycles", cycles, 32);
        checkOutput("hilo_hold", {31'h0, hold_ok}, 32'h1);
        if (read_during) checkOutput("stall_during_run", {31'h0, stall_ok}, 32'h1);
        model_hi = exp_hi;
        model_lo = exp_lo;
        checkOutput("result_hi", data_Hi, exp_hi);
        checkOutput("result_lo", data_Lo, exp_lo);
        checkOutput("done_pulse", {31'h0, flag_Done}, 32'h1);
        checkOutput("divzero_flag", {31'h0, flag_DivZero}, {31'h0, exp_dz});
    endtask

    // Issue a single-cycle op (MTHI, MTLO or an invalid code) from IDLE
    task automatic applyMove(input logic [2:0] op, input logic [31:0] a);
        @(negedge clock);
        flag_Start = 1'b1;
        op_Sel     = op;
        data_Reg1  = a;
        data_Reg2  = $urandom;
        @(posedge clock);
        #1;
        flag_Start = 1'b0;
        if (op == 3'b100) model_hi = a;
        if (op == 3'b101) model_lo = a;
        checkOutput("move_hi", data_Hi, model_hi);
        checkOutput("move_lo", data_Lo, model_lo);
        checkOutput("move_no_done", {31'h0, flag_Done}, 32'h0);
        checkOutput("move_no_busy", {31'h0, flag_Busy}, 32'h0);
    endtask

    // Main sequence: reset, directed test-plan items, then randomized traffic
    initial begin
        int          cycles;
        bit          stall_ok;
        bit          hold_ok;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        reset_n       = 1'b0;
        flag_Start    = 1'b0;
        op_Sel        = 3'b000;
        data_Reg1     = 32'h0;
        data_Reg2     = 32'h0;
        flag_ReadHiLo = 1'b0;
        #12;
        checkOutput("reset_hi", data_Hi, 32'h0);
        checkOutput("reset_lo", data_Lo, 32'h0);
        checkOutput("reset_busy", {31'h0, flag_Busy}, 32'h0);
        checkOutput("reset_done", {31'h0, flag_Done}, 32'h0);
        checkOutput("reset_divzero", {31'h0, flag_DivZero}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checkOutput("multu_max_hi", data_Hi, 32'hFFFF_FFFE);
        checkOutput("multu_max_lo", data_Lo, 32'h0000_0001);
        @(posedge clock);
        #1;
        checkOutput("done_one_cycle", {31'h0, flag_Done}, 32'h0);
        flag_ReadHiLo = 1'b1;
        #1;
        checkOutput("idle_no_stall", {31'h0, flag_Stall}, 32'h0);
        flag_ReadHiLo = 1'b0;

        applyStimulus(3'b010, 32'd100, 32'd7, 1'b1);
        checkOutput("divu_100_7_lo", data_Lo, 32'd14);
        checkOutput("divu_100_7_hi", data_Hi, 32'd2);

        applyStimulus(3'b010, 32'h1234, 32'h0, 1'b0);
        checkOutput("divzero_lo", data_Lo, 32'hFFFF_FFFF);
        checkOutput("divzero_hi", data_Hi, 32'h1234);

        applyMove(3'b100, 32'hDEAD_BEEF);
        applyMove(3'b101, 32'h0000_CAFE);
        checkOutput("mthi_value", data_Hi, 32'hDEAD_BEEF);

        // MTLO held by control while a MULTU is in flight
        modelOp(3'b000, 32'd3, 32'd5, exp_hi, exp_lo, exp_dz);
        @(negedge clock);
        flag_Start = 1'b1;
        op_Sel     = 3'b000;
        data_Reg1  = 32'd3;
        data_Reg2  = 32'd5;
        @(posedge clock);
        #1;
        op_Sel     = 3'b101;
        data_Reg1  = 32'h5555_5555;
        #1;
        stall_ok = 1'b1;
        hold_ok  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (flag_Stall !== 1'b1) stall_ok = 1'b0;
            if (data_Lo !== model_lo) hold_ok = 1'b0;
            @(posedge clock);
            #1;
        end
        flag_Start = 1'b0;
        checkOutput("mtlo_busy_stall", {31'h0, stall_ok}, 32'h1);
        checkOutput("mtlo_busy_lo_hold", {31'h0, hold_ok}, 32'h1);
        waitIdle(1'b0, cycles, stall_ok, hold_ok);
        model_hi = exp_hi;
        model_lo = exp_lo;
        checkOutput("mul_after_mtlo_lo", data_Lo, 32'd15);
        checkOutput("mul_after_mtlo_hi", data_Hi, 32'd0);

        applyStimulus(3'b001, 32'hFFFF_FFFD, 32'd5, 1'b0);
        applyStimulus(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0);
        applyStimulus(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
`ifdef MDU_SIGNED_EN
        checkOutput("div_min_neg1_lo", data_Lo, 32'h8000_0000);
        checkOutput("div_min_neg1_hi", data_Hi, 32'h0);
`endif

        // Reset asserted ten cycles into a MULTU aborts it
        @(negedge clock);
        flag_Start = 1'b1;
        op_Sel     = 3'b000;
        data_Reg1  = 32'h1234_5678;
        data_Reg2  = 32'h9ABC_DEF0;
        @(posedge clock);
        #1;
        flag_Start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        model_hi = 32'h0;
        model_lo = 32'h0;
        checkOutput("abort_busy", {31'h0, flag_Busy}, 32'h0);
        checkOutput("abort_hi", data_Hi, 32'h0);
        checkOutput("abort_lo", data_Lo, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'h0;
            else if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 255));
            if (!op[2]) applyStimulus(op, a, b, n[0]);
            else applyMove(op, a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
